pwm_generator: RTL
==================

# pwm_generator

Downstream consumer of `sync_fifo` in the PWM datapath. Pulls duty-cycle words from the FIFO read port, holds one word in a prefetch shadow register, and produces one PWM period per word. Output runs at `2^WIDTH` counter ticks per period, with an optional clock prescaler. When the FIFO runs dry, the last duty word is repeated and an underrun is flagged.

## Interface

Parameters:
- `WIDTH`, 8: duty/counter width in bits; must equal the FIFO `WIDTH`; min 2, max 16.
- `DIV`, 1: clock cycles per counter tick; min 1, max 65535.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk`  in  1  system clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_en`  in  1  PWM enable, level.
- `i_fifo`  in  WIDTH  FIFO read data (FIFO `o_fifo`), valid the cycle after a read strobe.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `o_fifo_re`  out  1  FIFO read enable, registered single-cycle pulse.
- `o_pwm`  out  1  PWM output, registered.
- `o_period_done`  out  1  one-cycle pulse on every period wrap.
- `o_underrun`  out  1  one-cycle pulse when a wrap finds no shadow word.

## Operation

Fetch FSM (`F_IDLE`, `F_READ`, `F_CAPT`):
- `F_IDLE`: if `!r_next_valid && !i_fifo_empty`, set `o_fifo_re` to 1 and go to `F_READ`.
- `F_READ`: set `o_fifo_re` to 0 and go to `F_CAPT`.
- `F_CAPT`: `r_next <= i_fifo`, `r_next_valid <= 1`, then go to `F_IDLE`.
- Exactly one read is in flight at a time, so no double reads can occur even though the FIFO empty flag updates one edge after the strobe.
- Fetch runs regardless of `i_en`.

Prescaler:
- `r_div` counts 0..DIV-1.
- `tick` = `i_en && r_div == DIV-1`.
- With DIV=1, `tick` = `i_en`.

Counter and duty:
- While `!i_en`: `r_cnt` is held at all-ones, `r_div` is held at 0, and `o_pwm` is 0.
- On `tick`, `r_cnt` increments modulo `2^WIDTH`.
- Wrap is `tick && r_cnt == all-ones`. On wrap:
  - `o_period_done` pulses.
  - If `r_next_valid`: `r_duty <= r_next` and `r_next_valid <= 0`.
  - Otherwise: `r_duty` is unchanged and `o_underrun` pulses.
- If a wrap and an `F_CAPT` capture occur in the same cycle, the wrap sees the old `r_next_valid` (0) and flags underrun. The captured word is used at the next wrap.

PWM output:
- `o_pwm <= i_en && (r_cnt < r_duty)`, an unsigned compare.
- Duty 0 gives a constant low output.
- Duty `2^WIDTH-1` gives high for all but 1 tick per period.
- Because the counter is held at all-ones while disabled, the first tick after `i_en` rises performs a wrap. The first period therefore starts with a freshly loaded word, or is flagged as an underrun.

Reset (asynchronous, all registers):
- `o_pwm`, `o_fifo_re`, `o_period_done`, `o_underrun` reset to 0.
- `r_cnt` resets to all-ones; `r_div`, `r_duty`, `r_next` reset to 0.
- `r_next_valid` resets to 0; the fetch FSM resets to `F_IDLE`.
- A reset mid-read discards the in-flight word. The FIFO's own reset discards its contents.

## Timing

- Read strobe to shadow valid: `o_fifo_re` is high in cycle t, the FIFO updates `o_fifo` at edge t+1, and `r_next` is captured at edge t+2.
- Minimum spacing between read strobes is 3 cycles.
- Counter to output latency: `o_pwm` reflects the compare of the previous cycle's `r_cnt`/`r_duty`, a 1-cycle lag.
- Period length is `DIV * 2^WIDTH` clock cycles.
- High time is `DIV * duty` cycles.
- `o_period_done` and `o_underrun` are asserted the cycle after the wrap edge and last exactly 1 cycle.
- With `i_en` high and the FIFO kept non-empty, a new word is consumed every period with no gap. Prefetch completes within 3 cycles, far less than one period.
- Deasserting `i_en` has effect at the next edge: `o_pwm` goes to 0 one cycle later and the counter returns to all-ones.

## Structure

- Package `pwm_pkg`:
  - Fetch state enum `fetch_state_t` (`F_IDLE`, `F_READ`, `F_CAPT`).
  - Helper localparam `DIV_W = (DIV>1) ? $clog2(DIV) : 1`.
- One sub-module, `pwm_prescaler`: parameter `DIV`, inputs `i_clk`, `i_rst_n`, `i_en`, output `o_tick`. It is reused by other timing blocks.
- The fetch FSM, shadow register, counter and compare stay in `pwm_generator`.

## Test plan

- **Reset:** with WIDTH=4, DIV=1, assert `i_rst_n`=0 mid-run. All outputs go to 0 immediately and asynchronously; after release, `o_fifo_re` stays 0 while `i_fifo_empty`=1.
- **Single word:** FIFO holds 4, `i_en`=1. Exactly one `o_fifo_re` pulse occurs. Then, repeating every 16 cycles, `o_pwm` is high for 4 cycles and low for 12, `o_period_done` pulses once per period, and `o_underrun` pulses on every wrap after the first.
- **Back-to-back words:** FIFO is loaded with 0, 15, 8. Successive periods show 0, 15 and 8 high cycles with no idle gap and no underrun until the FIFO is drained.
- **Prescale:** with WIDTH=4, DIV=3 and duty 5, the period is 48 cycles with a 15-cycle high time. `o_period_done` spacing is 48 cycles.
- **Enable toggle:** drop `i_en` mid-period. `o_pwm` goes to 0 one cycle later. On re-enable with shadow valid (duty 2), the first wrap occurs after 1 tick and the period begins with 2 high cycles.
- **Underrun at start:** `i_en`=1 with an empty FIFO. The first tick gives `o_underrun`=1, `o_period_done`=1 and `o_pwm`=0 throughout. A later write of 6 is loaded at the following wrap.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the PWM datapath.
// Holds the fetch FSM state encoding and the prescaler width helper.
package pwm_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_READ,
        F_CAPT
    } fetch_state_t;

    // Width of a 0..div-1 counter, never less than one bit.
    function automatic int div_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides the clock into one tick every DIV cycles.
// Ports: i_clk, i_rst_n (async, active-low), i_en (level), o_tick.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int DIV_W = div_w(DIV);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (!i_en) begin
            div_d = '0;
        end else if (div_q == LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign o_tick = i_en && (div_q == LAST);

endmodule

// File: rtl/pwm_generator.sv
// pwm_generator: FIFO-fed PWM, one duty word per 2^WIDTH-tick period.
// Ports: i_clk, i_rst_n, i_en, i_fifo, i_fifo_empty -> o_fifo_re, o_pwm, o_period_done, o_underrun.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_fifo,
    input  logic             i_fifo_empty,
    output logic             o_fifo_re,
    output logic             o_pwm,
    output logic             o_period_done,
    output logic             o_underrun
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("pwm_generator: WIDTH out of range");
    end
    if (DIV < 1 || DIV > 65535) begin : g_bad_div
        $error("pwm_generator: DIV out of range");
    end

    fetch_state_t     state_q, state_d;
    logic             fifo_re_q, fifo_re_d;
    logic [WIDTH-1:0] next_q, next_d;
    logic             next_valid_q, next_valid_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pwm_q, pwm_d;
    logic             period_done_q, period_done_d;
    logic             underrun_q, underrun_d;

    logic tick;
    logic wrap;
    logic capture;

    pwm_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (i_en),
        .o_tick (tick)
    );

    assign wrap    = tick && (cnt_q == '1);
    assign capture = (state_q == F_CAPT);

    // One read in flight at a time: the empty flag lags the strobe by an
    // edge, so the FSM never looks at it again until the word is captured.
    always_comb begin
        state_d   = state_q;
        fifo_re_d = 1'b0;
        unique case (state_q)
            F_IDLE: begin
                if (!next_valid_q && !i_fifo_empty) begin
                    fifo_re_d = 1'b1;
                    state_d   = F_READ;
                end
            end
            F_READ:  state_d = F_CAPT;
            F_CAPT:  state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
    end

    // A capture in the same cycle as a wrap is not visible to that wrap;
    // the wrap sees the old (empty) shadow and the word waits a period.
    always_comb begin
        next_d       = capture ? i_fifo : next_q;
        next_valid_d = next_valid_q;
        duty_d       = duty_q;
        if (capture) begin
            next_valid_d = 1'b1;
        end else if (wrap) begin
            next_valid_d = 1'b0;
        end
        if (wrap && next_valid_q) begin
            duty_d = next_q;
        end
    end

    // Held at all-ones while disabled so the first enabled tick wraps
    // and starts a period with a freshly loaded word.
    always_comb begin
        cnt_d = cnt_q;
        if (!i_en) begin
            cnt_d = '1;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        pwm_d         = i_en && (cnt_q < duty_q);
        period_done_d = wrap;
        underrun_d    = wrap && !next_valid_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= F_IDLE;
            fifo_re_q     <= 1'b0;
            next_q        <= '0;
            next_valid_q  <= 1'b0;
            duty_q        <= '0;
            cnt_q         <= '1;
            pwm_q         <= 1'b0;
            period_done_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fifo_re_q     <= fifo_re_d;
            next_q        <= next_d;
            next_valid_q  <= next_valid_d;
            duty_q        <= duty_d;
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_d;
            period_done_q <= period_done_d;
            underrun_q    <= underrun_d;
        end
    end

    assign o_fifo_re     = fifo_re_q;
    assign o_pwm         = pwm_q;
    assign o_period_done = period_done_q;
    assign o_underrun    = underrun_q;

endmodule
